// File: rtl/axi_burst_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_burst_arbiter : N-way beat arbiter that locks the grant for a whole burst
// Revision 1.0
// ----------------------------------------------------------------------------
module axi_burst_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LEN_W     = 8,
  parameter int PRIO_MODE = 0,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       in_req_i,
  input  logic [NUM_REQ*LEN_W-1:0] in_len_i,
  output logic [NUM_REQ-1:0]       in_ack_o,
  output logic                     out_req_o,
  input  logic                     out_ack_i,
  output logic [IDX_W-1:0]         out_sel_o,
  output logic                     busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic [LEN_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_sel;
  logic [IDX_W-1:0]   r_rr;

  logic [IDX_W-1:0]   w_win;
  logic [LEN_W-1:0]   w_win_len;
  logic               w_sel_req;
  logic [IDX_W-1:0]   w_cur;
  logic               w_hs;

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_REQ-1:0] vec);
    lowest = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) lowest = IDX_W'(i);
    end
  endfunction

  generate
    if (PRIO_MODE == 1) begin : g_fixed
      always_comb begin
        w_win = lowest(in_req_i);
      end
    end else begin : g_rr
      logic [NUM_REQ-1:0] w_hi;
      // Requests above the pointer win first; otherwise wrap to the lowest index.
      always_comb begin
        w_hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
          w_hi[i] = in_req_i[i] && (IDX_W'(i) > r_rr);
        end
        w_win = (|w_hi) ? lowest(w_hi) : lowest(in_req_i);
      end
    end
  endgenerate

  always_comb begin
    w_win_len = '0;
    w_sel_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i)) w_win_len = in_len_i[i*LEN_W +: LEN_W];
      if (r_sel == IDX_W'(i)) w_sel_req = in_req_i[i];
    end
  end

  always_comb begin
    if (r_state == ST_LOCKED) begin
      out_req_o = w_sel_req;
      w_cur     = r_sel;
    end else begin
      out_req_o = |in_req_i;
      w_cur     = w_win;
    end
  end

  generate
    if (NUM_REQ == 1) begin : g_single
      assign out_sel_o = '0;
    end else begin : g_multi
      assign out_sel_o = w_cur;
    end
  endgenerate

  assign w_hs   = out_req_o && out_ack_i;
  assign busy_o = r_busy;

  always_comb begin
    in_ack_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_ack_o[i] = w_hs && (out_sel_o == IDX_W'(i));
    end
  end

  // Length is captured only on the first beat; the counter holds remaining beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_rr    <= IDX_W'(NUM_REQ - 1);
    end else if (w_hs) begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_len == '0) begin
            r_rr <= w_win;
          end else begin
            r_state <= ST_LOCKED;
            r_busy  <= 1'b1;
            r_sel   <= w_win;
            r_cnt   <= w_win_len;
          end
        end
        ST_LOCKED: begin
          if (r_cnt == LEN_W'(1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_rr    <= r_sel;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - LEN_W'(1);
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_arbiter.sv
`default_nettype none
// Testbench for axi_burst_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model (round-robin and fixed DUTs).
module tb_axi_burst_arbiter;

  localparam int N  = 4;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_req = '0;
  logic [N*LW-1:0] in_len = '0;
  logic            out_ack = 1'b0;

  logic [N-1:0] rr_ack, fp_ack;
  logic         rr_oreq, fp_oreq, rr_busy, fp_busy;
  logic [1:0]   rr_sel, fp_sel;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axi_burst_arbiter #(.NUM_REQ(N), .LEN_W(LW), .PRIO_MODE(0)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .in_req_i(in_req), .in_len_i(in_len),
    .in_ack_o(rr_ack), .out_req_o(rr_oreq), .out_ack_i(out_ack),
    .out_sel_o(rr_sel), .busy_o(rr_busy)
  );

  axi_burst_arbiter #(.NUM_REQ(N), .LEN_W(LW), .PRIO_MODE(1)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n), .in_req_i(in_req), .in_len_i(in_len),
    .in_ack_o(fp_ack), .out_req_o(fp_oreq), .out_ack_i(out_ack),
    .out_sel_o(fp_sel), .busy_o(fp_busy)
  );

  // ---------------- reference model (index 0 = round-robin, 1 = fixed) ----
  int         m_ptr[2];
  bit         m_locked[2];
  int         m_owner[2];
  int         m_left[2];
  int         exp_sel[2];
  bit         exp_req[2];
  logic [N-1:0] exp_ack[2];
  bit         exp_busy[2];

  function automatic int lenof(int i);
    return int'(in_len[i*LW +: LW]);
  endfunction

  task automatic set_len(input int i, input int v);
    in_len[i*LW +: LW] = LW'(v);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = N - 1; m_locked[m] = 0; m_owner[m] = 0; m_left[m] = 0;
    end
  endtask

  function automatic int pick(int m);
    if (in_req == '0) return 0;
    if (m == 1) begin
      for (int i = 0; i < N; i++) if (in_req[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int idx = (m_ptr[m] + k) % N;
        if (in_req[idx]) return idx;
      end
    end
    return 0;
  endfunction

  task automatic model_calc();
    for (int m = 0; m < 2; m++) begin
      if (m_locked[m]) begin
        exp_sel[m] = m_owner[m];
        exp_req[m] = in_req[m_owner[m]];
      end else begin
        exp_sel[m] = pick(m);
        exp_req[m] = (in_req != '0);
      end
      exp_ack[m] = '0;
      if (exp_req[m] && out_ack) exp_ack[m][exp_sel[m]] = 1'b1;
      exp_busy[m] = m_locked[m];
    end
  endtask

  task automatic model_advance();
    model_calc();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (exp_req[m] && out_ack) begin
        if (!m_locked[m]) begin
          if (lenof(exp_sel[m]) == 0) m_ptr[m] = exp_sel[m];
          else begin
            m_locked[m] = 1; m_owner[m] = exp_sel[m]; m_left[m] = lenof(exp_sel[m]);
          end
        end else begin
          m_left[m]--;
          if (m_left[m] == 0) begin
            m_locked[m] = 0; m_ptr[m] = m_owner[m];
          end
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_req = '0; in_len = '0; out_ack = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_req = 4'b0110; out_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #3;
      n_total++;
      if ({rr_sel, rr_oreq, rr_ack, rr_busy} !== {2'd1, 1'b1, 4'b0010, 1'b0})
        $display("FAIL reset_rr c%0d: sel=%0d req=%b ack=%b busy=%b, expected sel=1 req=1 ack=0010 busy=0",
                 c, rr_sel, rr_oreq, rr_ack, rr_busy);
      else n_pass++;
      n_total++;
      if ({fp_sel, fp_oreq, fp_ack, fp_busy} !== {2'd1, 1'b1, 4'b0010, 1'b0})
        $display("FAIL reset_fp c%0d: sel=%0d req=%b ack=%b busy=%b, expected sel=1 req=1 ack=0010 busy=0",
                 c, fp_sel, fp_oreq, fp_ack, fp_busy);
      else n_pass++;
      next_cycle();
    end
    in_req = '0; out_ack = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_rr_rotation();
    logic [3:0] acks [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    in_req = 4'b1111; out_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      n_total++;
      if (rr_sel !== 2'(k) || rr_ack !== acks[k] || rr_busy !== 1'b0)
        $display("FAIL rr_rotation beat%0d: sel=%0d ack=%b busy=%b, expected sel=%0d ack=%b busy=0",
                 k, rr_sel, rr_ack, rr_busy, k, acks[k]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_burst_lock();
    logic [1:0] sels [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    logic       bsy  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    in_req = 4'b0101; set_len(0, 3); out_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) set_len(0, 0);   // must be ignored while locked
      #3;
      n_total++;
      if (rr_sel !== sels[k] || rr_busy !== bsy[k] || rr_ack !== (4'b0001 << sels[k]))
        $display("FAIL burst_lock beat%0d: sel=%0d busy=%b ack=%b, expected sel=%0d busy=%b ack=%b",
                 k, rr_sel, rr_busy, rr_ack, sels[k], bsy[k], 4'b0001 << sels[k]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_drop_request();
    do_reset();
    in_req = 4'b0010; set_len(1, 2); out_ack = 1'b1;
    #3;
    n_total++;
    if (rr_sel !== 2'd1 || rr_ack !== 4'b0010 || rr_busy !== 1'b0)
      $display("FAIL drop_first: sel=%0d ack=%b busy=%b, expected sel=1 ack=0010 busy=0", rr_sel, rr_ack, rr_busy);
    else n_pass++;
    next_cycle();
    in_req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #3;
      n_total++;
      if (rr_oreq !== 1'b0 || rr_sel !== 2'd1 || rr_ack !== 4'b0000 || rr_busy !== 1'b1)
        $display("FAIL drop_hold c%0d: req=%b sel=%0d ack=%b busy=%b, expected req=0 sel=1 ack=0000 busy=1",
                 c, rr_oreq, rr_sel, rr_ack, rr_busy);
      else n_pass++;
      next_cycle();
    end
    in_req = 4'b1010;
    for (int c = 0; c < 2; c++) begin
      #3;
      n_total++;
      if (rr_sel !== 2'd1 || rr_ack !== 4'b0010 || rr_busy !== 1'b1)
        $display("FAIL drop_resume c%0d: sel=%0d ack=%b busy=%b, expected sel=1 ack=0010 busy=1",
                 c, rr_sel, rr_ack, rr_busy);
      else n_pass++;
      next_cycle();
    end
    #3;
    n_total++;
    if (rr_sel !== 2'd3 || rr_ack !== 4'b1000 || rr_busy !== 1'b0)
      $display("FAIL drop_after: sel=%0d ack=%b busy=%b, expected sel=3 ack=1000 busy=0", rr_sel, rr_ack, rr_busy);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    in_req = 4'b1110; out_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #3;
      n_total++;
      if (fp_sel !== 2'd1 || fp_ack !== 4'b0010 || fp_busy !== 1'b0)
        $display("FAIL fixed_prio c%0d: sel=%0d ack=%b busy=%b, expected sel=1 ack=0010 busy=0",
                 c, fp_sel, fp_ack, fp_busy);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    in_req = 4'b0100; out_ack = 1'b1;   // single beat leaves the pointer at 2
    next_cycle();
    set_len(2, 7);
    #3;
    n_total++;
    if (rr_sel !== 2'd2 || rr_busy !== 1'b0 || rr_ack !== 4'b0100)
      $display("FAIL midrst_first: sel=%0d busy=%b ack=%b, expected sel=2 busy=0 ack=0100", rr_sel, rr_busy, rr_ack);
    else n_pass++;
    next_cycle();
    #3;
    n_total++;
    if (rr_sel !== 2'd2 || rr_busy !== 1'b1 || rr_ack !== 4'b0100)
      $display("FAIL midrst_beat2: sel=%0d busy=%b ack=%b, expected sel=2 busy=1 ack=0100", rr_sel, rr_busy, rr_ack);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rr_busy !== 1'b0)
      $display("FAIL midrst_async: busy=%b, expected busy=0", rr_busy);
    else n_pass++;
    next_cycle();
    rst_n = 1'b1; in_req = 4'b1100; out_ack = 1'b0;
    #3;
    n_total++;
    if (rr_sel !== 2'd2 || rr_busy !== 1'b0 || rr_oreq !== 1'b1 || rr_ack !== 4'b0000)
      $display("FAIL midrst_regrant: sel=%0d busy=%b req=%b ack=%b, expected sel=2 busy=0 req=1 ack=0000",
               rr_sel, rr_busy, rr_oreq, rr_ack);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_max_burst();
    int bad;
    bad = 0;
    do_reset();
    in_req = 4'b0001; set_len(0, 255); out_ack = 1'b1;
    for (int b = 0; b < 256; b++) begin
      #3;
      if (rr_ack !== 4'b0001 || rr_busy !== (b != 0)) bad++;
      next_cycle();
    end
    n_total++;
    if (bad != 0)
      $display("FAIL max_burst_beats: bad beats=%0d, expected 0", bad);
    else n_pass++;
    set_len(0, 0);
    for (int c = 0; c < 2; c++) begin
      #3;
      n_total++;
      if (rr_busy !== 1'b0 || rr_ack !== 4'b0001)
        $display("FAIL max_burst_end c%0d: busy=%b ack=%b, expected busy=0 ack=0001", c, rr_busy, rr_ack);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_ack_without_req();
    do_reset();
    in_req = '0; out_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      n_total++;
      if (rr_oreq !== 1'b0 || rr_ack !== 4'b0000 || rr_sel !== 2'd0 || rr_busy !== 1'b0)
        $display("FAIL idle_ack c%0d: req=%b ack=%b sel=%0d busy=%b, expected req=0 ack=0000 sel=0 busy=0",
                 c, rr_oreq, rr_ack, rr_sel, rr_busy);
      else n_pass++;
      next_cycle();
    end
    in_req = 4'b1111; out_ack = 1'b0;
    #3;
    n_total++;
    if (rr_sel !== 2'd0 || rr_oreq !== 1'b1 || rr_ack !== 4'b0000)
      $display("FAIL idle_ack_ptr: sel=%0d req=%b ack=%b, expected sel=0 req=1 ack=0000", rr_sel, rr_oreq, rr_ack);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_n   = ($urandom_range(0, 149) != 0);
      in_req  = N'($urandom);
      out_ack = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        set_len(i, ($urandom_range(0, 7) == 0) ? $urandom_range(3, 20) : $urandom_range(0, 2));
      if (!rst_n) model_reset();
      #3;
      model_calc();
      n_total++;
      if ({rr_sel, rr_oreq, rr_ack, rr_busy} !== {2'(exp_sel[0]), exp_req[0], exp_ack[0], exp_busy[0]})
        $display("FAIL random_rr c%0d: sel=%0d req=%b ack=%b busy=%b, expected sel=%0d req=%b ack=%b busy=%b",
                 c, rr_sel, rr_oreq, rr_ack, rr_busy, exp_sel[0], exp_req[0], exp_ack[0], exp_busy[0]);
      else n_pass++;
      n_total++;
      if ({fp_sel, fp_oreq, fp_ack, fp_busy} !== {2'(exp_sel[1]), exp_req[1], exp_ack[1], exp_busy[1]})
        $display("FAIL random_fp c%0d: sel=%0d req=%b ack=%b busy=%b, expected sel=%0d req=%b ack=%b busy=%b",
                 c, fp_sel, fp_oreq, fp_ack, fp_busy, exp_sel[1], exp_req[1], exp_ack[1], exp_busy[1]);
      else n_pass++;
      @(posedge clk);
      model_advance();
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_rr_rotation();
    test_burst_lock();
    test_drop_request();
    test_fixed_priority();
    test_reset_mid_burst();
    test_max_burst();
    test_ack_without_req();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi_burst_arbiter.md
AXI_BURST_ARBITER -- requirements
Module: axi_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requestors (>=1).
REQ-002 SHALL have parameter LEN_W, default 8, giving the width of each burst-length field (AXI len encoding, beats-1).
REQ-003 SHALL have parameter PRIO_MODE, default 0, selecting arbitration: 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-004 SHALL define local IDX_W = max(1, $clog2(NUM_REQ)).
REQ-005 SHALL have port clk_i  input  1  clock; one clock, all state on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port in_req_i  input  NUM_REQ  per-requestor request.
REQ-008 SHALL have port in_len_i  input  NUM_REQ*LEN_W  per-requestor burst length; slice i is bits [i*LEN_W +: LEN_W].
REQ-009 SHALL have port in_ack_o  output  NUM_REQ  per-requestor acknowledge (one beat accepted).
REQ-010 SHALL have port out_req_o  output  1  request to downstream.
REQ-011 SHALL have port out_ack_i  input  1  downstream beat acknowledge.
REQ-012 SHALL have port out_sel_o  output  IDX_W  index of the currently selected requestor.
REQ-013 SHALL have port busy_o  output  1  high while a multi-beat grant is locked.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, LOCKED.
REQ-015 In IDLE, SHALL assert out_req_o = OR of in_req_i and drive out_sel_o with the combinational winner; out_sel_o = 0 when no request.
REQ-016 In round-robin mode, the winner SHALL be the first requesting index strictly after pointer rr_q, searching cyclically.
REQ-017 In fixed mode, the winner SHALL be the lowest requesting index, and rr_q SHALL have no effect.
REQ-018 SHALL drive in_ack_o[out_sel_o] = out_ack_i && out_req_o; all other in_ack_o bits 0; in_ack_o one-hot or zero in all states.
REQ-019 On an IDLE beat handshake (out_req_o && out_ack_i): if in_len_i[winner] == 0, SHALL stay IDLE and set rr_q = winner; otherwise SHALL go LOCKED, capture sel_q = winner and cnt_q = in_len_i[winner].
REQ-020 in_len_i SHALL be sampled only at the first-beat handshake; later changes are ignored.
REQ-021 In LOCKED, out_sel_o SHALL equal sel_q, out_req_o SHALL equal in_req_i[sel_q], busy_o SHALL be 1, and no rearbitration SHALL occur, even if sel_q drops its request or others assert.
REQ-022 In LOCKED, each handshake SHALL decrement cnt_q; a handshake with cnt_q == 1 SHALL return to IDLE and set rr_q = sel_q.
REQ-023 Handshake-to-ack latency SHALL be 0 cycles (combinational); the grant decision SHALL take effect in the same cycle as the request in IDLE.
REQ-024 Maximum burst SHALL be 2^LEN_W beats; cnt_q SHALL be LEN_W bits and never wrap below 0.
REQ-025 out_ack_i without out_req_o SHALL be ignored (no state change, no in_ack_o).
REQ-026 With NUM_REQ == 1, out_sel_o SHALL be constant 0 and behaviour otherwise identical.
REQ-027 busy_o SHALL be 0 in IDLE, including the cycle of a first-beat handshake.

Reset
REQ-028 On rst_ni low, SHALL asynchronously enter IDLE with cnt_q = 0, sel_q = 0, rr_q = NUM_REQ-1 (index 0 has first round-robin priority).
REQ-029 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration restarts from REQ-028 values.
REQ-030 During reset, outputs SHALL follow the IDLE equations with the reset state (out_req_o reflects in_req_i, busy_o = 0).

Verification
REQ-031 NUM_REQ=4, RR, in_req_i=4'b1111, all len=0, out_ack_i=1 for 4 cycles -> out_sel_o 0,1,2,3; in_ack_o 0001,0010,0100,1000.
REQ-032 RR, in_req_i=4'b0101, len[0]=3, ack every cycle -> sel 0 for 4 beats, busy_o=1 on beats 2-4, then sel 2.
REQ-033 Locked on requestor 1 with cnt_q=2, in_req_i[1] drops for 3 cycles while in_req_i[3]=1 -> out_req_o=0, out_sel_o=1, no in_ack_o[3]; resumes on req 1.
REQ-034 PRIO_MODE=1, in_req_i=4'b1110 constant, len=0, ack each cycle -> out_sel_o stays 1; in_ack_o[3:2] never asserted.
REQ-035 rst_ni pulsed low during LOCKED beat 2 of len=7 burst on requestor 2 -> busy_o=0 immediately, next grant with in_req_i=4'b1100 goes to 2 (rr_q=3 resets pointer).
REQ-036 LEN_W=8, len=255 on requestor 0 -> exactly 256 acks before IDLE; cnt_q never wraps.
